crypt_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one byte-wide encryption engine (permute-then-XOR datapath) between NREQ requesters. It accepts one byte at a time from the winning requester, drives the engine's `en`/`din`, waits for the engine's `v` or a timeout, and returns the result tagged with the requester ID. It sits between the client ports and the single engine instance.

---
 rtl/crypt_pkg.sv | 42 ++++
 rtl/crypt_rr_pick.sv | 51 +++++
 rtl/crypt_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_crypt_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crypt_pkg
// Description : Shared definitions for the crypt engine arbiter: sequencer
//               state encoding, engine key constants, the engine bit
//               permutation order and a helper that applies it.
// Revision    : 1.0 - initial release
// ============================================================================
package crypt_pkg;

  // Sequencer states. Width is explicit so the encoding is fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } crypt_state_t;

  // Engine round keys. The engine XORs all three into its output, so the
  // combined key is what a reference model needs.
  localparam logic [7:0] K1 = 8'h3E;
  localparam logic [7:0] K2 = 8'h49;
  localparam logic [7:0] K3 = 8'h7E;
  localparam logic [7:0] KX = 8'h09;

  // Permutation source indices, listed MSB first: output bit 7 takes input
  // bit 0, output bit 6 takes input bit 5, ..., output bit 0 takes input
  // bit 1. Field b (bits [b*3 +: 3]) is the source for output bit b.
  localparam logic [23:0] PERM_IDX = {3'd0, 3'd5, 3'd2, 3'd6,
                                      3'd7, 3'd4, 3'd3, 3'd1};

  // Applies the engine's bit permutation to one byte.
  function automatic logic [7:0] crypt_perm(input logic [7:0] i_din);
    logic [7:0] v_out;
    v_out = '0;
    for (int b = 0; b < 8; b++) begin
      v_out[b] = i_din[PERM_IDX[b*3 +: 3]];
    end
    return v_out;
  endfunction

endpackage : crypt_pkg
`default_nettype wire

// File: rtl/crypt_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : crypt_rr_pick
// Description : Combinational round-robin picker. Searches i_req_valid
//               upward from i_last+1, wrapping modulo NREQ, and reports the
//               first asserted requester.
// Ports       : i_req_valid - per-requester request flags
//               i_last      - index granted most recently
//               o_grant     - one-hot grant (all zero when no request)
//               o_idx       - binary index of the granted requester
//               o_hit       - at least one requester is asserting
// Revision    : 1.0 - initial release
// ============================================================================
module crypt_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req_valid,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_hit
);

  // One extra bit so last+offset cannot overflow before the wrap.
  logic [IW:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_hit   = 1'b0;
    w_pos   = '0;
    // Offset 1 is the highest-priority position; offset NREQ is the
    // requester served last time, which only wins when it is alone.
    for (int off = 1; off <= NREQ; off++) begin
      w_pos = {1'b0, i_last} + (IW+1)'(off);
      if (w_pos >= (IW+1)'(NREQ)) begin
        w_pos = w_pos - (IW+1)'(NREQ);
      end
      if (!o_hit && i_req_valid[w_pos[IW-1:0]]) begin
        o_hit = 1'b1;
        o_idx = w_pos[IW-1:0];
      end
    end
    if (o_hit) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule : crypt_rr_pick
`default_nettype wire

// File: rtl/crypt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : crypt_arbiter
// Description : Round-robin arbiter and sequencer sharing one byte-wide
//               encryption engine between NREQ requesters. Accepts one byte
//               from the winning requester, holds it on the engine input
//               while waiting for the engine's valid (or a timeout), then
//               returns the result tagged with the requester index.
// Ports       : clock, rst        - clock, asynchronous active-low reset
//               i_req_valid/data  - requester side (data packed i*N +: N)
//               o_req_ready       - one-hot accept strobe (IDLE only)
//               o_rsp_*           - response channel with i_rsp_ready
//               o_eng_en/din      - engine drive
//               i_eng_dout/v      - engine result
//               o_busy            - sequencer not in IDLE
//               o_stat_done/err   - response counters
// Build macro : CRYPT_ARB_STATS_EN - builds the saturating response
//               counters; when undefined the stat ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module crypt_arbiter
  import crypt_pkg::*;
#(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [NREQ-1:0]           i_req_valid,
  input  logic [NREQ*N-1:0]         i_req_data,
  output logic [NREQ-1:0]           o_req_ready,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [$clog2(NREQ)-1:0]   o_rsp_id,
  output logic [N-1:0]              o_rsp_data,
  output logic                      o_rsp_err,
  output logic                      o_eng_en,
  output logic [N-1:0]              o_eng_din,
  input  logic [N-1:0]              i_eng_dout,
  input  logic                      i_eng_v,
  output logic                      o_busy,
  output logic [15:0]               o_stat_done,
  output logic [15:0]               o_stat_err
);

  localparam int            IW         = $clog2(NREQ);
  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

  crypt_state_t   r_state;
  crypt_state_t   w_state_nxt;

  logic [IW-1:0]  r_last;
  logic [IW-1:0]  r_id;
  logic [N-1:0]   r_data;
  logic [N-1:0]   r_rsp_data;
  logic           r_rsp_err;
  logic [TW-1:0]  r_timer;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_gidx;
  logic            w_hit;
  logic            w_accept;
  logic            w_rsp_hs;
  logic            w_tmo;

  crypt_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req_valid (i_req_valid),
    .i_last      (r_last),
    .o_grant     (w_grant),
    .o_idx       (w_gidx),
    .o_hit       (w_hit)
  );

  assign w_tmo = (r_timer == C_TMO_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    o_eng_en    = 1'b0;
    o_rsp_valid = 1'b0;
    o_busy      = 1'b1;
    w_accept    = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy      = 1'b0;
        // The picker only grants an asserted requester, so a grant is
        // already a completed handshake.
        o_req_ready = w_grant;
        w_accept    = w_hit;
        if (w_hit) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        o_eng_en = 1'b1;
        if (i_eng_v || w_tmo) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        w_rsp_hs    = i_rsp_ready;
        // Returning to IDLE first means no grant in the handshake cycle.
        if (i_rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture, wait timer and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      // Requester 0 is first in line after reset.
      r_last     <= IW'(NREQ - 1);
      r_id       <= '0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_timer    <= '0;
    end else begin
      if (w_accept) begin
        r_data  <= i_req_data[w_gidx*N +: N];
        r_id    <= w_gidx;
        r_last  <= w_gidx;
        r_timer <= '0;
      end
      if (r_state == WAIT) begin
        // Engine valid wins over a timeout landing in the same cycle.
        if (i_eng_v) begin
          r_rsp_data <= i_eng_dout;
          r_rsp_err  <= 1'b0;
        end else if (w_tmo) begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end
    end
  end

  assign o_rsp_id   = r_id;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_err  = r_rsp_err;
  assign o_eng_din  = r_data;

  // --------------------------------------------------------------------------
  // Optional response statistics
  // --------------------------------------------------------------------------
`ifdef CRYPT_ARB_STATS_EN
  logic [15:0] r_stat_done;
  logic [15:0] r_stat_err;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_stat_done <= '0;
      r_stat_err  <= '0;
    end else if (w_rsp_hs) begin
      if (r_rsp_err) begin
        if (r_stat_err != 16'hFFFF) begin
          r_stat_err <= r_stat_err + 16'd1;
        end
      end else begin
        if (r_stat_done != 16'hFFFF) begin
          r_stat_done <= r_stat_done + 16'd1;
        end
      end
    end
  end

  assign o_stat_done = r_stat_done;
  assign o_stat_err  = r_stat_err;
`else
  logic w_unused_hs;
  assign w_unused_hs = w_rsp_hs;
  assign o_stat_done = '0;
  assign o_stat_err  = '0;
`endif

endmodule : crypt_arbiter
`default_nettype wire

// File: tb/tb_crypt_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_crypt_arbiter
// Description : Self-checking bench for crypt_arbiter. A transaction-level
//               model of the arbiter and a simple engine model run alongside
//               the DUT; every cycle the DUT outputs are compared with the
//               model, followed by directed scenarios with literal
//               expectations and a randomized soak.
// Build macro : CRYPT_ARB_STATS_EN - also expects live statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crypt_arbiter;

  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic              clock = 1'b0;
  logic              rst   = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic              rsp_ready;
  logic [N-1:0]      eng_dout;
  logic              eng_v;

  logic [NREQ-1:0]   o_req_ready;
  logic              o_rsp_valid;
  logic [1:0]        o_rsp_id;
  logic [N-1:0]      o_rsp_data;
  logic              o_rsp_err;
  logic              o_eng_en;
  logic [N-1:0]      o_eng_din;
  logic              o_busy;
  logic [15:0]       o_stat_done;
  logic [15:0]       o_stat_err;

  crypt_arbiter #(
    .N       (N),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .o_eng_en    (o_eng_en),
    .o_eng_din   (o_eng_din),
    .i_eng_dout  (eng_dout),
    .i_eng_v     (eng_v),
    .o_busy      (o_busy),
    .o_stat_done (o_stat_done),
    .o_stat_err  (o_stat_err)
  );

  always #5 clock = ~clock;

  // Model state: phase 0 = idle, 1 = waiting on engine, 2 = responding.
  int         m_phase, m_last, m_id, m_wcnt, m_done, m_errc;
  logic [7:0] m_data, m_rdata;
  logic       m_rerr;
  int         e_delay, e_force;
  bit         spur;

  int         cyc, acc_cyc, rsp_cyc, dut_hs, cap_id;
  bit         rsp_seen;
  logic [7:0] cap_data;
  logic       cap_err;
  int         glog[$];

  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: cycle budget exhausted (cycle %0d)", name, cyc);
  endtask

  // Engine transfer function: permute the byte, then XOR the combined key.
  function automatic logic [7:0] eng_fn(input logic [7:0] d);
    return {d[0], d[5], d[2], d[6], d[7], d[4], d[3], d[1]} ^ 8'h09;
  endfunction

  // First asserted requester after 'last', wrapping; -1 when none.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      int c;
      c = (last + off) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_last  = NREQ - 1;
    m_id    = 0;
    m_wcnt  = 0;
    m_data  = 8'h00;
    m_rdata = 8'h00;
    m_rerr  = 1'b0;
    m_done  = 0;
    m_errc  = 0;
  endtask

  // Compare every DUT output with what the model says for this cycle.
  task automatic check_outputs();
    int              g;
    logic [NREQ-1:0] exp_rr;
    int              exp_sd, exp_se;
    g      = rr_pick(req_valid, m_last);
    exp_rr = '0;
    if (m_phase == 0 && g >= 0) exp_rr[g] = 1'b1;
    chk("req_ready", 32'(o_req_ready), 32'(exp_rr));
    chk("busy",      32'(o_busy),      32'(m_phase != 0));
    chk("eng_en",    32'(o_eng_en),    32'(m_phase == 1));
    chk("eng_din",   32'(o_eng_din),   32'(m_data));
    chk("rsp_valid", 32'(o_rsp_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      chk("rsp_id",   32'(o_rsp_id),   32'(m_id));
      chk("rsp_data", 32'(o_rsp_data), 32'(m_rdata));
      chk("rsp_err",  32'(o_rsp_err),  32'(m_rerr));
    end
`ifdef CRYPT_ARB_STATS_EN
    exp_sd = m_done;
    exp_se = m_errc;
`else
    exp_sd = 0;
    exp_se = 0;
`endif
    chk("stat_done", 32'(o_stat_done), 32'(exp_sd));
    chk("stat_err",  32'(o_stat_err),  32'(exp_se));
    if (o_rsp_valid && rsp_ready) dut_hs++;
    if (o_rsp_valid && !rsp_seen) begin
      rsp_seen = 1'b1;
      rsp_cyc  = cyc;
      cap_id   = int'(o_rsp_id);
      cap_data = o_rsp_data;
      cap_err  = o_rsp_err;
    end
  endtask

  // Advance the model across one rising edge using the inputs just applied.
  task automatic model_update();
    int g;
    case (m_phase)
      0: begin
        g = rr_pick(req_valid, m_last);
        if (g >= 0) begin
          m_data   = req_data[g*N +: N];
          m_id     = g;
          m_last   = g;
          m_wcnt   = 0;
          m_phase  = 1;
          acc_cyc  = cyc;
          rsp_seen = 1'b0;
          glog.push_back(g);
          e_delay  = (e_force >= 0) ? e_force : $urandom_range(0, TIMEOUT + 2);
        end
      end
      1: begin
        m_wcnt++;
        if (eng_v) begin
          m_rdata = eng_dout;
          m_rerr  = 1'b0;
          m_phase = 2;
        end else if (m_wcnt == TIMEOUT) begin
          m_rdata = 8'h00;
          m_rerr  = 1'b1;
          m_phase = 2;
        end
      end
      default: begin
        if (rsp_ready) begin
          m_phase = 0;
          if (m_rerr) begin
            if (m_errc < 65535) m_errc++;
          end else begin
            if (m_done < 65535) m_done++;
          end
        end
      end
    endcase
    cyc++;
  endtask

  // One clock cycle. Called just after a rising edge with stimulus set.
  task automatic step();
    if (m_phase == 1 && e_delay != 0 && (m_wcnt + 1) == e_delay) begin
      eng_v    = 1'b1;
      eng_dout = eng_fn(m_data);
    end else if (spur && m_phase != 1 && $urandom_range(0, 7) == 0) begin
      eng_v    = 1'b1;
      eng_dout = 8'($urandom);
    end else begin
      eng_v    = 1'b0;
      eng_dout = 8'($urandom);
    end
    #1;
    check_outputs();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic run_idle(input int budget);
    int k;
    k = 0;
    while (m_phase != 0 && k < budget) begin
      step();
      k++;
    end
    if (m_phase != 0) bound_fail("run_idle");
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    chk({tag, "_busy"},      32'(o_busy),      32'd0);
    chk({tag, "_eng_en"},    32'(o_eng_en),    32'd0);
    chk({tag, "_eng_din"},   32'(o_eng_din),   32'd0);
    chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  32'(o_rsp_data),  32'd0);
    chk({tag, "_rsp_id"},    32'(o_rsp_id),    32'd0);
    chk({tag, "_rsp_err"},   32'(o_rsp_err),   32'd0);
    model_reset();
    @(posedge clock);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, hs0;
    int exp_order [6];
    exp_order = '{0, 1, 2, 3, 0, 1};

    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    eng_v     = 1'b0;
    eng_dout  = '0;
    e_force   = -1;
    e_delay   = 0;
    spur      = 1'b0;
    cyc       = 0;
    acc_cyc   = 0;
    rsp_cyc   = 0;
    dut_hs    = 0;
    rsp_seen  = 1'b0;
    cap_id    = 0;
    cap_data  = '0;
    cap_err   = 1'b0;
    model_reset();

    // Reset values.
    rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy",      32'(o_busy),      32'd0);
    chk("rst_eng_en",    32'(o_eng_en),    32'd0);
    chk("rst_eng_din",   32'(o_eng_din),   32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(o_rsp_data),  32'd0);
    chk("rst_rsp_id",    32'(o_rsp_id),    32'd0);
    chk("rst_rsp_err",   32'(o_rsp_err),   32'd0);
    chk("rst_req_ready", 32'(o_req_ready), 32'd0);
    rst = 1'b1;

    // Single request, engine valid on the third WAIT cycle.
    req_valid = 4'b0001;
    req_data  = 32'h0000_0000;
    e_force   = 3;
    step();
    req_valid = '0;
    run_idle(40);
    chk("t1_seen", 32'(rsp_seen), 32'd1);
    chk("t1_id",   32'(cap_id),   32'd0);
    chk("t1_data", 32'(cap_data), 32'h09);
    chk("t1_err",  32'(cap_err),  32'd0);
    chk("t1_lat",  32'(rsp_cyc - acc_cyc), 32'd4);

    // Permutation check through requester 2.
    req_valid = 4'b0100;
    req_data  = 32'h0001_0000;
    e_force   = 2;
    step();
    req_valid = '0;
    run_idle(40);
    chk("t2_id",   32'(cap_id),   32'd2);
    chk("t2_data", 32'(cap_data), 32'h89);
    chk("t2_err",  32'(cap_err),  32'd0);

    // Timeout with the engine silent.
    req_valid = 4'b0001;
    req_data  = 32'($urandom);
    e_force   = 0;
    step();
    req_valid = '0;
    run_idle(40);
    chk("t3_err",  32'(cap_err),  32'd1);
    chk("t3_data", 32'(cap_data), 32'h00);
    chk("t3_lat",  32'(rsp_cyc - acc_cyc), 32'd16);
    chk("t3_idle", 32'(o_busy),   32'd0);

    // Engine valid exactly on the timeout cycle still wins.
    req_valid = 4'b1000;
    req_data  = 32'h5A00_0000;
    e_force   = TIMEOUT;
    step();
    req_valid = '0;
    run_idle(40);
    chk("t3b_err",  32'(cap_err),  32'd0);
    chk("t3b_data", 32'(cap_data), 32'(eng_fn(8'h5A)));

    // Response backpressure: five cycles of rsp_ready low.
    req_valid = 4'b0010;
    req_data  = 32'($urandom);
    e_force   = 2;
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    k = 0;
    while (m_phase != 2 && k < 20) begin
      step();
      k++;
    end
    if (m_phase != 2) bound_fail("bp_reach_resp");
    req_valid = 4'b1111;
    hs0 = dut_hs;
    repeat (5) step();
    chk("bp_no_hs", 32'(dut_hs - hs0), 32'd0);
    chk("bp_id",    32'(cap_id),       32'd1);
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    chk("bp_one_hs", 32'(dut_hs - hs0), 32'd1);
    run_idle(10);

    // Reset in the middle of WAIT drops the byte.
    req_valid = 4'b0100;
    req_data  = 32'($urandom);
    e_force   = 0;
    step();
    req_valid = '0;
    step();
    step();
    async_reset("t5");

    // Fairness with everyone requesting continuously.
    glog.delete();
    req_valid = 4'b1111;
    e_force   = 1;
    k = 0;
    while (glog.size() < 6 && k < 100) begin
      req_data = 32'($urandom);
      step();
      k++;
    end
    if (glog.size() < 6) bound_fail("rr_collect");
    for (int i = 0; i < 6 && i < glog.size(); i++) begin
      chk("rr_order", 32'(glog[i]), 32'(exp_order[i]));
    end
    req_valid = '0;
    run_idle(40);

    // Randomized soak.
    spur    = 1'b1;
    e_force = -1;
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      req_data  = 32'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (i == 1500) async_reset("soak");
    end
    spur      = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    run_idle(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_crypt_arbiter
`default_nettype wire
